// File: rtl/neuron_feeder_if.sv
// Bundle of every handshake and data signal between the feeder, its upstream
// source, the neuron memories/core and the downstream result consumer.
interface neuron_feeder_if #(
    parameter int WIDTH = 16,
    parameter int LEN   = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_x;
    logic [WIDTH-1:0]       in_w;
    logic                   mem_we;
    logic [$clog2(LEN)-1:0] mem_addr;
    logic [WIDTH-1:0]       mem_x;
    logic [WIDTH-1:0]       mem_w;
    logic                   nrn_start;
    logic                   nrn_ready;
    logic [WIDTH-1:0]       nrn_out;
    logic                   res_valid;
    logic [WIDTH-1:0]       res_data;
    logic                   res_err;
    logic                   res_ack;
    logic                   busy;

    modport master (
        input  in_valid, in_x, in_w, nrn_ready, nrn_out, res_ack,
        output in_ready, mem_we, mem_addr, mem_x, mem_w, nrn_start,
               res_valid, res_data, res_err, busy
    );

    modport slave (
        output in_valid, in_x, in_w, nrn_ready, nrn_out, res_ack,
        input  in_ready, mem_we, mem_addr, mem_x, mem_w, nrn_start,
               res_valid, res_data, res_err, busy
    );
endinterface

// File: rtl/neuron_feeder.sv
// Streams LEN (x, w) pairs into the neuron memories, kicks the neuron, waits
// (with timeout) for its result and holds that result until acknowledged.
module neuron_feeder #(
    parameter int WIDTH   = 16,
    parameter int LEN     = 8,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    neuron_feeder_if.master bus
);
    localparam int AW = $clog2(LEN);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_RESULT} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    wcnt_q, wcnt_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_err_q, res_err_d;
    logic             in_ready;
    logic             xfer;

    // Gated by rst so nothing is accepted while reset is being applied.
    assign in_ready = (state_q == S_LOAD) && !rst;
    assign xfer     = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        case (state_q)
            S_LOAD: begin
                if (xfer) begin
                    if (cnt_q == AW'(LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            S_START: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // WAIT lasts at most TIMEOUT cycles; a late result on the
                // final cycle still counts as a normal capture.
                if (bus.nrn_ready) begin
                    res_data_d = bus.nrn_out;
                    res_err_d  = 1'b0;
                    state_d    = S_RESULT;
                end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    state_d    = S_RESULT;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            S_RESULT: begin
                if (bus.res_ack) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = xfer;
    assign bus.mem_addr  = cnt_q;
    assign bus.mem_x     = bus.in_x;
    assign bus.mem_w     = bus.in_w;
    assign bus.nrn_start = (state_q == S_START);
    assign bus.res_valid = (state_q == S_RESULT);
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign bus.busy      = (state_q != S_LOAD);
endmodule

// File: tb/tb_neuron_feeder.sv
// Directed bench for neuron_feeder: load, gaps, timeout, held result,
// mid-load reset, reset from WAIT and ignored/late neuron ready.
module tb_neuron_feeder;
    localparam int W = 16;
    localparam int L = 8;
    localparam int T = 255;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    neuron_feeder_if #(.WIDTH(W), .LEN(L)) bus ();

    neuron_feeder #(.WIDTH(W), .LEN(L), .TIMEOUT(T)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Each cycle begins 1 time unit after the rising edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [W-1:0] base);
        for (int i = 0; i < L; i++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = base + W'(i);
            bus.in_w     = 16'd1;
            adv();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_x = 16'h5555; bus.in_w = 16'h5555;
        bus.nrn_ready = 1'b0; bus.nrn_out = '0; bus.res_ack = 1'b0;
        adv(); adv();
        #1;
        n_chk++;
        if ({bus.in_ready, bus.mem_we, bus.nrn_start, bus.res_valid, bus.busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/we/start/vld/busy=%b want 00000",
                     {bus.in_ready, bus.mem_we, bus.nrn_start, bus.res_valid, bus.busy});
        end
        n_chk++;
        if ({bus.res_data, bus.res_err} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_res: got data=%h err=%b want 0000/0", bus.res_data, bus.res_err);
        end
        adv();
        rst = 1'b0; bus.in_valid = 1'b0;
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_full_pass();
        for (int i = 0; i < L; i++) begin
            bus.in_valid = 1'b1; bus.in_x = W'(i + 1); bus.in_w = 16'd2;
            #1;
            n_chk++;
            if ({bus.mem_we, bus.mem_addr, bus.mem_x, bus.mem_w} !== {1'b1, 3'(i), 16'(i + 1), 16'd2}) begin
                n_fail++;
                $display("FAIL full_write%0d: got we=%b addr=%0d x=%h w=%h want 1/%0d/%h/0002",
                         i, bus.mem_we, bus.mem_addr, bus.mem_x, bus.mem_w, i, i + 1);
            end
            adv();
        end
        bus.in_x = 16'h0099; // still offered, must be refused
        #1;
        n_chk++;
        if ({bus.nrn_start, bus.in_ready, bus.mem_we, bus.busy} !== 4'b1001) begin
            n_fail++;
            $display("FAIL full_start: got start/rdy/we/busy=%b want 1001",
                     {bus.nrn_start, bus.in_ready, bus.mem_we, bus.busy});
        end
        bus.in_valid = 1'b0;
        adv();
        for (int j = 0; j < 5; j++) begin
            bus.nrn_ready = (j == 4); bus.nrn_out = (j == 4) ? 16'h0048 : 16'hFFFF;
            #1;
            n_chk++;
            if ({bus.nrn_start, bus.res_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL full_wait%0d: got start/vld=%b want 00", j, {bus.nrn_start, bus.res_valid});
            end
            adv();
        end
        bus.nrn_ready = 1'b0;
        #1;
        n_chk++;
        if ({bus.res_valid, bus.res_data, bus.res_err} !== {1'b1, 16'h0048, 1'b0}) begin
            n_fail++;
            $display("FAIL full_result: got vld=%b data=%h err=%b want 1/0048/0",
                     bus.res_valid, bus.res_data, bus.res_err);
        end
        bus.res_ack = 1'b1;
        adv();
        bus.res_ack = 1'b0;
        #1;
        n_chk++;
        if ({bus.in_ready, bus.res_valid, bus.res_data} !== {2'b10, 16'h0048}) begin
            n_fail++;
            $display("FAIL full_after_ack: got rdy=%b vld=%b data=%h want 1/0/0048",
                     bus.in_ready, bus.res_valid, bus.res_data);
        end
    endtask

    task automatic test_gapped();
        for (int k = 0; k < 2 * L; k++) begin
            bus.in_valid = (k % 2 == 0); bus.in_x = W'(k); bus.in_w = ~W'(k);
            #1;
            n_chk++;
            if (k % 2 == 0) begin
                if ({bus.mem_we, bus.mem_addr, bus.mem_x} !== {1'b1, 3'(k / 2), 16'(k)}) begin
                    n_fail++;
                    $display("FAIL gap_write%0d: got we=%b addr=%0d x=%h want 1/%0d/%h",
                             k, bus.mem_we, bus.mem_addr, bus.mem_x, k / 2, k);
                end
            end else if ({bus.mem_we, bus.nrn_start} !== {1'b0, k == 2 * L - 1}) begin
                n_fail++;
                $display("FAIL gap_idle%0d: got we=%b start=%b want 0/%b",
                         k, bus.mem_we, bus.nrn_start, k == 2 * L - 1);
            end
            adv();
        end
        bus.in_valid = 1'b0;
        bus.nrn_ready = 1'b1; bus.nrn_out = 16'h1234;
        adv();
        bus.nrn_ready = 1'b0;
        #1;
        n_chk++;
        if ({bus.res_valid, bus.res_data, bus.res_err} !== {1'b1, 16'h1234, 1'b0}) begin
            n_fail++;
            $display("FAIL gap_result: got vld=%b data=%h err=%b want 1/1234/0",
                     bus.res_valid, bus.res_data, bus.res_err);
        end
        bus.res_ack = 1'b1;
        adv();
        bus.res_ack = 1'b0;
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        load8(16'h0100);
        adv(); // START
        for (int j = 0; j < T; j++) begin
            #1;
            if (bus.res_valid !== 1'b0) early++;
            adv();
        end
        n_chk++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL timeout_early: got %0d early result cycles want 0", early);
        end
        #1;
        n_chk++;
        if ({bus.res_valid, bus.res_data, bus.res_err} !== {1'b1, 16'h0000, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_result: got vld=%b data=%h err=%b want 1/0000/1",
                     bus.res_valid, bus.res_data, bus.res_err);
        end
        bus.res_ack = 1'b1;
        adv();
        bus.res_ack = 1'b0;
        #1;
        n_chk++;
        if ({bus.in_ready, bus.busy, bus.res_err} !== 3'b101) begin
            n_fail++;
            $display("FAIL timeout_ack: got rdy/busy/err=%b want 101", {bus.in_ready, bus.busy, bus.res_err});
        end
    endtask

    task automatic test_held_result();
        int bad;
        bad = 0;
        load8(16'h0200);
        adv(); // START
        adv(); // WAIT 0
        bus.nrn_ready = 1'b1; bus.nrn_out = 16'hBEEF;
        adv();
        bus.nrn_ready = 1'b0; bus.nrn_out = 16'h0000;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = (c % 2 == 0); bus.in_x = 16'h7777;
            #1;
            if ({bus.res_valid, bus.res_data, bus.res_err, bus.in_ready, bus.mem_we}
                !== {1'b1, 16'hBEEF, 3'b000}) bad++;
            adv();
        end
        bus.in_valid = 1'b0;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL held_result: got %0d unstable cycles want 0", bad);
        end
        bus.res_ack = 1'b1;
        adv();
        bus.res_ack = 1'b0;
    endtask

    task automatic test_midload_reset();
        int bad;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_x = W'(i); bus.in_w = 16'd3;
            adv();
        end
        bus.in_valid = 1'b0; rst = 1'b1;
        adv();
        rst = 1'b0;
        for (int i = 0; i < L; i++) begin
            bus.in_valid = 1'b1; bus.in_x = W'(16'h40 + i); bus.in_w = 16'd4;
            #1;
            if ({bus.mem_we, bus.mem_addr, bus.nrn_start} !== {1'b1, 3'(i), 1'b0}) bad++;
            if (i == 0) begin
                n_chk++;
                if (bus.mem_addr !== 3'd0) begin
                    n_fail++;
                    $display("FAIL midrst_addr0: got %0d want 0", bus.mem_addr);
                end
            end
            adv();
        end
        bus.in_valid = 1'b0;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midrst_reload: got %0d bad load cycles want 0", bad);
        end
        #1;
        n_chk++;
        if (bus.nrn_start !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_start: got %b want 1", bus.nrn_start);
        end
    endtask

    // Entered in the START cycle left by test_midload_reset.
    task automatic test_early_ready();
        bus.nrn_ready = 1'b1; bus.nrn_out = 16'hDEAD;
        adv();
        for (int j = 0; j < T; j++) begin
            bus.nrn_ready = (j == T - 1); bus.nrn_out = (j == T - 1) ? 16'h0777 : 16'hDEAD;
            #1;
            if (j == 0) begin
                n_chk++;
                if ({bus.res_valid, bus.busy} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL early_ignored: got vld/busy=%b want 01", {bus.res_valid, bus.busy});
                end
            end
            adv();
        end
        bus.nrn_ready = 1'b0;
        #1;
        n_chk++;
        if ({bus.res_valid, bus.res_data, bus.res_err} !== {1'b1, 16'h0777, 1'b0}) begin
            n_fail++;
            $display("FAIL late_ready_wins: got vld=%b data=%h err=%b want 1/0777/0",
                     bus.res_valid, bus.res_data, bus.res_err);
        end
        bus.res_ack = 1'b1;
        adv();
        bus.res_ack = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        load8(16'h0300);
        adv(); // START
        adv(); adv(); // WAIT
        rst = 1'b1;
        adv();
        rst = 1'b0;
        #1;
        n_chk++;
        if ({bus.busy, bus.in_ready, bus.res_valid, bus.res_data, bus.res_err} !== {3'b010, 16'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL wait_reset: got busy=%b rdy=%b vld=%b data=%h err=%b want 0/1/0/0000/0",
                     bus.busy, bus.in_ready, bus.res_valid, bus.res_data, bus.res_err);
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_gapped();
        test_timeout();
        test_held_result();
        test_midload_reset();
        test_early_ready();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/neuron_feeder.md
NEURON_FEEDER -- requirements
Module: neuron_feeder

Interface
REQ-001 Parameter WIDTH, default 16, bit width of input elements, weights and neuron result.
REQ-002 Parameter LEN, default 8, number of (input, weight) pairs per neuron evaluation; LEN >= 2.
REQ-003 Parameter TIMEOUT, default 255, max WAIT cycles before the evaluation is aborted.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream offers one (x, w) pair.
REQ-007 in_ready  output  1  feeder accepts a pair this cycle.
REQ-008 in_x  input  WIDTH  input-vector element.
REQ-009 in_w  input  WIDTH  weight-vector element.
REQ-010 mem_we  output  1  write strobe to neuron input/weight memories.
REQ-011 mem_addr  output  clog2(LEN)  element index being written.
REQ-012 mem_x  output  WIDTH  element written to input-vector memory.
REQ-013 mem_w  output  WIDTH  element written to weight-vector memory.
REQ-014 nrn_start  output  1  start pulse to neuron.
REQ-015 nrn_ready  input  1  neuron result valid.
REQ-016 nrn_out  input  WIDTH  neuron result.
REQ-017 res_valid  output  1  captured result available downstream.
REQ-018 res_data  output  WIDTH  captured result.
REQ-019 res_err  output  1  result aborted by timeout.
REQ-020 res_ack  input  1  downstream consumes result.
REQ-021 busy  output  1  high in any state other than LOAD.

Function
REQ-022 FSM states SHALL be LOAD, START, WAIT, RESULT; encoding free.
REQ-023 in_ready SHALL equal (state==LOAD) and SHALL be 0 whenever rst is high.
REQ-024 Transfer occurs in a cycle with in_valid && in_ready; in_x/in_w ignored otherwise.
REQ-025 mem_we SHALL be combinational = transfer; mem_addr = element counter; mem_x = in_x; mem_w = in_w (same cycle, zero latency).
REQ-026 Element counter SHALL increment by 1 per transfer, range 0..LEN-1, no other writes.
REQ-027 Transfer with counter==LEN-1 SHALL move LOAD->START next edge and clear counter to 0.
REQ-028 START SHALL last exactly one cycle with nrn_start=1; nrn_start=0 in every other state; START->WAIT unconditionally.
REQ-029 nrn_ready SHALL be ignored outside WAIT (including during START).
REQ-030 In WAIT, nrn_ready=1 SHALL capture nrn_out into res_data, clear res_err, go to RESULT next edge.
REQ-031 WAIT cycle counter starts at 0 on entry; if it reaches TIMEOUT with nrn_ready still 0, go to RESULT with res_data=0, res_err=1.
REQ-032 nrn_ready=1 in the same cycle the timeout would fire SHALL win (normal capture, res_err=0).
REQ-033 res_valid SHALL equal (state==RESULT); res_data/res_err held stable while res_valid=1.
REQ-034 res_ack=1 in RESULT SHALL move to LOAD next edge; res_ack outside RESULT ignored.
REQ-035 res_data/res_err SHALL retain last value after leaving RESULT until next capture.
REQ-036 No new pairs accepted from end of LOAD until return to LOAD (back-pressure via in_ready=0).

Reset
REQ-037 rst=1 at a clock edge SHALL force state=LOAD, element and WAIT counters=0, res_data=0, res_err=0, from any state including mid-load and WAIT.
REQ-038 Reset values: in_ready=0 during rst, 1 first cycle after; mem_we=0, nrn_start=0, res_valid=0, busy=0.
REQ-039 Partially loaded elements before reset SHALL be discarded; next load restarts at address 0.

Verification
REQ-040 Full pass: 8 back-to-back pairs x=1..8, w=2 -> mem_we 8 cycles, addr 0..7; nrn_start one cycle after last; nrn_ready with nrn_out=0x0048 after 5 cycles -> res_valid=1, res_data=0x0048, res_err=0.
REQ-041 Gapped input: in_valid toggled every other cycle -> exactly 8 writes, addresses 0..7 consecutive, no write when in_valid=0.
REQ-042 Timeout: nrn_ready held 0 -> RESULT after TIMEOUT WAIT cycles, res_data=0, res_err=1; res_ack -> LOAD, in_ready=1.
REQ-043 Held result: res_ack=0 for 20 cycles -> res_valid and res_data stable, in_ready=0, in_valid pulses cause no mem_we.
REQ-044 Mid-load reset: rst after 3 pairs -> next pair written to addr 0, 8 more pairs required before nrn_start.
REQ-045 Early nrn_ready: nrn_ready=1 during START cycle only -> ignored, WAIT proceeds; also nrn_ready on timeout cycle -> res_err=0.
